// File: rtl/multi_adc_capture.sv
// rtl/multi_adc_capture.sv - lockstep SPI capture of NUM_CH serial ADCs into a show-ahead FIFO
//
// One shared SCLK/CS frame clocks every ADC at once; each MISO lane has its
// own shift register, while a single bit counter decides which bits are kept.
// Each completed frame becomes one NUM_CH*SAMPLE_W word (channel 0 in the LSBs)
// that is pushed into an internal show-ahead FIFO.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   start            request one frame (only honoured in IDLE)
//   continuous       keep issuing frames back-to-back while high
//   miso[NUM_CH]     serial data from the ADCs, bit i = channel i
//   spi_sclk         SPI clock, idles high
//   spi_cs_n         chip select, active low
//   busy             high whenever the sequencer is not IDLE
//   rd_en            pop the FIFO head (ignored while empty)
//   rd_data          FIFO head, valid while !empty
//   empty, full      FIFO status, derived from count
//   count            entries currently held
//   overflow         sticky: a frame was dropped because the FIFO was full
//   clr_ovf          clears overflow (a simultaneous drop wins)
module multi_adc_capture #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 10,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 4,
    parameter int CLK_DIV    = 7,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [NUM_CH-1:0]            miso,
    output logic                         spi_sclk,
    output logic                         spi_cs_n,
    output logic                         busy,
    input  logic                         rd_en,
    output logic [NUM_CH*SAMPLE_W-1:0]   rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int DW    = NUM_CH * SAMPLE_W;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] KEEP_LO  = BIT_W'(LEAD_BITS);
    localparam logic [BIT_W-1:0] KEEP_HI  = BIT_W'(LEAD_BITS + SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_WRITE = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              phase_q, phase_d;   // within SHIFT: 0 = sclk low half, 1 = high half
    logic              sample_en;
    logic              push;
    logic              div_last;

    logic [DW-1:0]     sr_q, sr_d;
    logic              shift_en;

    logic [DW-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              do_push, do_pop, drop;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    assign div_last = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        sample_en = 1'b0;
        push      = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                phase_d = 1'b0;
                if (start || continuous) begin
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_SHIFT: begin
                if (div_last) begin
                    div_d = '0;
                    if (!phase_q) begin
                        // End of the low half: sclk rises now, so capture MISO.
                        phase_d   = 1'b1;
                        sample_en = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_WRITE: begin
                push    = 1'b1;
                div_d   = '0;
                state_d = continuous ? S_GAP : S_IDLE;
            end

            S_GAP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_SETUP;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign spi_cs_n = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    assign spi_sclk = !((state_q == S_SHIFT) && !phase_q);
    assign busy     = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Lane shift registers: only the window [LEAD_BITS, LEAD_BITS+SAMPLE_W)
    // shifts, so exactly SAMPLE_W bits land per frame and no clear is needed
    // between frames.
    // ------------------------------------------------------------------
    assign shift_en = sample_en && (bit_q >= KEEP_LO) && (bit_q < KEEP_HI);

    always_comb begin
        sr_d = sr_q;
        if (shift_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sr_d[ch*SAMPLE_W +: SAMPLE_W] = {sr_q[ch*SAMPLE_W +: SAMPLE_W-1], miso[ch]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign do_pop = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        // A drop in the same cycle as clr_ovf keeps the flag set.
        ovf_d = drop || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= sr_q;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multi_adc_capture.sv
// tb/tb_multi_adc_capture.sv - scoreboard bench for multi_adc_capture with behavioural ADC models
module tb_multi_adc_capture;

    localparam int NUM_CH = 2;
    localparam int SW     = 10;
    localparam int FB     = 16;
    localparam int LB     = 4;
    localparam int CD     = 2;
    localparam int DEPTH  = 4;
    localparam int DW     = NUM_CH * SW;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset, start, continuous, rd_en, clr_ovf;
    logic [NUM_CH-1:0] miso;
    logic              spi_sclk, spi_cs_n, busy, empty, full, overflow;
    logic [DW-1:0]     rd_data;
    logic [CW-1:0]     count;

    multi_adc_capture #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SW), .FRAME_BITS(FB),
        .LEAD_BITS(LB), .CLK_DIV(CD), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .miso(miso), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .busy(busy),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // ADC models: a frame is the bit sequence fvec[ch][0..FB-1]; bit k is
    // driven on the k-th falling sclk edge. The sample occupies bits
    // LB..LB+SW-1, MSB first; everything else is filler.
    // ------------------------------------------------------------------
    logic [FB-1:0] fvec [NUM_CH];
    logic [DW-1:0] cur_word;
    logic [SW-1:0] adc_s;
    logic [DW-1:0] adc_w;
    int            k_drv;
    int            rises;
    bit            frame_open = 0;
    int            force_mode = 0;   // 0 random, 1 fixed 2A5/15A, 2 ones filler with zero sample

    always @(negedge spi_cs_n) begin
        if (spi_cs_n === 1'b0) begin
            k_drv      = 0;
            rises      = 0;
            frame_open = 1;
            adc_w      = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                case (force_mode)
                    1:       adc_s = (c == 0) ? 10'h2A5 : 10'h15A;
                    2:       adc_s = '0;
                    default: adc_s = SW'($urandom);
                endcase
                fvec[c] = (force_mode == 2) ? '1 : FB'($urandom);
                for (int j = 0; j < SW; j++) fvec[c][LB+j] = adc_s[SW-1-j];
                adc_w[c*SW +: SW] = adc_s;
            end
            cur_word = adc_w;
        end
    end

    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0 && k_drv < FB) begin
            for (int c = 0; c < NUM_CH; c++) miso[c] = fvec[c][k_drv];
            k_drv++;
        end
    end

    always @(posedge spi_sclk) begin
        if (spi_cs_n === 1'b0) rises++;
    end

    always @(posedge spi_cs_n) begin
        if (frame_open && !reset) check("sclk_rises_per_frame", 64'(rises), 64'(FB));
        frame_open = 0;
    end

    // ------------------------------------------------------------------
    // Reference FIFO + scoreboard monitor, evaluated at the falling clk edge.
    // Inputs are driven 2 time units after the rising edge, so the values
    // seen here are the ones the next rising edge will act on.
    // ------------------------------------------------------------------
    logic [DW-1:0] model_q [$];
    bit            ovf_m = 0;
    bit            frame_live = 0;
    int            writes_seen = 0;
    bit            m_pop, m_full, m_wr, m_drop;

    always @(negedge clk) begin
        check("count", 64'(count), 64'(model_q.size()));
        check("empty", 64'(empty), 64'(model_q.size() == 0));
        check("full", 64'(full), 64'(model_q.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(ovf_m));
        if (spi_cs_n === 1'b1) check("sclk_idle_high", 64'(spi_sclk), 64'(1));

        if (reset) begin
            model_q.delete();
            ovf_m      = 0;
            frame_live = 0;
        end else begin
            m_pop  = rd_en && (model_q.size() > 0);
            m_full = (model_q.size() == DEPTH);
            m_wr   = (spi_cs_n === 1'b1) && frame_live;
            m_drop = m_wr && m_full && !m_pop;
            if (m_pop) begin
                check("rd_data", 64'(rd_data), 64'(model_q[0]));
                void'(model_q.pop_front());
            end
            if (spi_cs_n === 1'b0) frame_live = 1;
            if (m_wr) begin
                frame_live = 0;
                writes_seen++;
                if (!m_drop) model_q.push_back(cur_word);
            end
            ovf_m = m_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_m);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n = 0;
        while (writes_seen < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(writes_seen), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("reach_idle", 64'(busy), 64'(0));
    endtask

    task automatic drain();
        int n = 0;
        while (model_q.size() > 0 && n < 4 * DEPTH) begin
            rd_en = 1'b1;
            tick();
            n++;
        end
        rd_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    localparam int WR_CYC = 1 + CD * (2 * FB + 2);

    int            first_low, last_low, low_cnt, first_ne, busy_ne, base, n;
    logic [DW-1:0] exp_word;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0;
        rd_en = 1'b0; clr_ovf = 1'b0; miso = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_cs_n", 64'(spi_cs_n), 64'(1));
        check("rst_sclk", 64'(spi_sclk), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));

        // Single frame, fixed samples: frame timing and word packing.
        force_mode = 1;
        first_low = -1; last_low = -1; low_cnt = 0; first_ne = -1; busy_ne = -1;
        pulse_start();
        for (int c = 1; c <= WR_CYC + 10; c++) begin
            if (spi_cs_n === 1'b0) begin
                if (first_low < 0) first_low = c;
                last_low = c;
                low_cnt++;
            end
            if (empty === 1'b0 && first_ne < 0) begin
                first_ne = c;
                busy_ne  = int'(busy);
            end
            tick();
        end
        check("lat_cs_low_first", 64'(first_low), 64'(1));
        check("lat_cs_low_last", 64'(last_low), 64'(WR_CYC - 1));
        check("lat_cs_low_cycles", 64'(low_cnt), 64'(WR_CYC - 1));
        check("lat_empty_falls", 64'(first_ne), 64'(WR_CYC + 1));
        check("lat_busy_after_write", 64'(busy_ne), 64'(0));
        exp_word = {10'h15A, 10'h2A5};
        check("fixed_word", 64'(rd_data), 64'(exp_word));
        check("fixed_count", 64'(count), 64'(1));
        drain();

        // Filler bits all ones, sample zero: alignment.
        force_mode = 2;
        base = writes_seen;
        pulse_start();
        wait_writes(base + 1, 200, "align_write");
        check("align_word_zero", 64'(rd_data), 64'(0));
        drain();
        force_mode = 0;

        // Continuous, no reads: fill, then drop frame 5.
        base = writes_seen;
        continuous = 1'b1;
        wait_writes(base + 4, 500, "cont_four_writes");
        continuous = 1'b0;
        wait_writes(base + 5, 200, "cont_fifth_write");
        wait_idle(50);
        check("ovf_full", 64'(full), 64'(1));
        check("ovf_count", 64'(count), 64'(DEPTH));
        check("ovf_flag", 64'(overflow), 64'(1));
        drain();
        check("ovf_sticky_after_drain", 64'(overflow), 64'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_cleared", 64'(overflow), 64'(0));

        // Full FIFO with a pop in the WRITE cycle of frame 5.
        base = writes_seen;
        continuous = 1'b1;
        wait_writes(base + 4, 500, "popw_four_writes");
        continuous = 1'b0;
        n = 0;
        while (spi_cs_n !== 1'b0 && n < 50) begin tick(); n++; end
        while (spi_cs_n !== 1'b1 && n < 200) begin tick(); n++; end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("popw_overflow", 64'(overflow), 64'(0));
        check("popw_count", 64'(count), 64'(DEPTH));
        drain();

        // Reset during SHIFT with a word already queued.
        base = writes_seen;
        pulse_start();
        wait_writes(base + 1, 200, "rst_pre_write");
        pulse_start();
        n = 0;
        while (rises < 7 && n < 200) begin tick(); n++; end
        reset = 1'b1;
        tick();
        check("midrst_cs_n", 64'(spi_cs_n), 64'(1));
        check("midrst_sclk", 64'(spi_sclk), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_empty", 64'(empty), 64'(1));
        check("midrst_count", 64'(count), 64'(0));
        reset = 1'b0;
        tick();
        base = writes_seen;
        pulse_start();
        wait_writes(base + 1, 200, "post_rst_write");
        drain();

        // Read while empty.
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        tick();
        check("underflow_count", 64'(count), 64'(0));

        // start while busy is ignored.
        base = writes_seen;
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_idle(200);
        repeat (100) tick();
        check("busy_start_writes", 64'(writes_seen), 64'(base + 1));
        check("busy_start_count", 64'(count), 64'(1));
        drain();

        // continuous dropped mid-frame: that frame completes, then IDLE.
        base = writes_seen;
        continuous = 1'b1;
        repeat (30) tick();
        continuous = 1'b0;
        wait_idle(200);
        repeat (20) tick();
        check("cont_drop_writes", 64'(writes_seen), 64'(base + 1));
        drain();

        // Randomised traffic against the scoreboard.
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < 400; c++) begin
                start   = ($urandom_range(0, 15) == 0);
                rd_en   = ($urandom_range(0, 5) == 0);
                clr_ovf = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 60) == 0) continuous = ~continuous;
                tick();
            end
            start = 1'b0; continuous = 1'b0; clr_ovf = 1'b0; rd_en = 1'b0;
            wait_idle(200);
            tick();
            drain();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
